// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg
//   Shared definitions for the register-file dump reader: default geometry
//   of the pipeline register file and the dump FSM state encoding.
//   No ports.
package regfile_dump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_EMIT_LO = 3'd2;
  localparam logic [2:0] ST_EMIT_HI = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/regfile_dump_snoop.sv
// regfile_dump_snoop
//   Tracks which registers have already been captured by the current dump
//   and raises a sticky stale flag when the pipeline writes one of them.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   i_clear        clear mask and stale (new dump starting)
//   i_active       a dump is in progress; writes outside a dump are ignored
//   i_capture      the pair i_cap_pair is being captured at this edge
//   i_cap_pair     pair number being captured
//   rf_we          snooped RegWrite
//   rf_waddr       snooped WriteReg
//   o_stale        sticky stale flag
module regfile_dump_snoop #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_capture,
  input  logic [ADDR_W-2:0] i_cap_pair,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  output logic              o_stale
);

  // Mask spans the full address space so any rf_waddr indexes it safely.
  localparam int MASK_W = 1 << ADDR_W;

  logic [MASK_W-1:0] r_mask;
  logic              r_stale;
  logic              w_hit_mask;
  logic              w_hit_cap;

  assign w_hit_mask = r_mask[rf_waddr];
  // A write landing on the same edge as its pair's capture is treated as
  // stale: the captured value is the pre-write one.
  assign w_hit_cap  = i_capture && (rf_waddr[ADDR_W-1:1] == i_cap_pair);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask  <= '0;
      r_stale <= 1'b0;
    end else if (i_clear) begin
      r_mask  <= '0;
      r_stale <= 1'b0;
    end else begin
      if (i_capture) begin
        r_mask[{i_cap_pair, 1'b0}] <= 1'b1;
        r_mask[{i_cap_pair, 1'b1}] <= 1'b1;
      end
      if (i_active && rf_we && (w_hit_mask || w_hit_cap))
        r_stale <= 1'b1;
    end
  end

  assign o_stale = r_stale;

endmodule

// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug/trace reader for the pipeline register file. On start it walks all
//   registers in even/odd pairs through the two read ports and emits each
//   value as a valid/ready (index, data) beat. Writes to already-captured
//   registers during the dump set a sticky stale flag.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 single-cycle request, ignored while busy
//   abort                 cancel a dump in progress (priority over handshake)
//   rd_addr1/rd_addr2     even/odd read addresses to the register file
//   rd_data1/rd_data2     combinational read data from the register file
//   rf_we/rf_waddr        snooped register-file write port
//   out_valid/out_ready   beat handshake
//   out_index/out_data    beat payload
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse after the last beat is accepted
//   stale                 sticky: captured register overwritten during dump
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              stale
);

  localparam logic [ADDR_W-2:0] LAST_PAIR = (ADDR_W-1)'(NUM_REGS/2 - 1);

  state_t            r_state;
  logic [ADDR_W-2:0] r_pair;
  logic [ADDR_W-1:0] r_rd_addr1;
  logic [ADDR_W-1:0] r_rd_addr2;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;

  logic              w_last;
  logic [ADDR_W-2:0] w_pair_nxt;
  logic              w_emit_lo;
  logic              w_emit_hi;
  logic              w_clear;
  logic              w_capture;
  logic              w_stale;

  assign w_last     = (r_pair == LAST_PAIR);
  assign w_pair_nxt = r_pair + 1'b1;
  assign w_emit_lo  = (r_state == ST_EMIT_LO);
  assign w_emit_hi  = (r_state == ST_EMIT_HI);
  assign w_clear    = (r_state == ST_IDLE) && start;
  assign w_capture  = (r_state == ST_READ);

  // FSM, pair counter and read addresses. Abort outranks every handshake;
  // in IDLE only start is considered, so start wins over a coincident abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pair     <= '0;
      r_rd_addr1 <= '0;
      r_rd_addr2 <= '0;
    end else if ((r_state != ST_IDLE) && abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_READ;
            r_pair     <= '0;
            r_rd_addr1 <= '0;
            r_rd_addr2 <= ADDR_W'(1);
          end
        end
        ST_READ: begin
          // Register 0 is hard-wired zero; optionally skip straight to r1.
          if ((SKIP_ZERO != 0) && (r_pair == '0))
            r_state <= ST_EMIT_HI;
          else
            r_state <= ST_EMIT_LO;
        end
        ST_EMIT_LO: begin
          if (out_ready)
            r_state <= ST_EMIT_HI;
        end
        ST_EMIT_HI: begin
          if (out_ready) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_state    <= ST_READ;
              r_pair     <= w_pair_nxt;
              r_rd_addr1 <= {w_pair_nxt, 1'b0};
              r_rd_addr2 <= {w_pair_nxt, 1'b1};
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding registers: loaded at the closing edge of READ while the read
  // addresses have been stable for the whole cycle.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_lo <= rd_data1;
      r_hi <= rd_data2;
    end
  end

  regfile_dump_snoop #(
    .ADDR_W (ADDR_W)
  ) u_snoop (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_active   (r_state != ST_IDLE),
    .i_capture  (w_capture),
    .i_cap_pair (r_pair),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .o_stale    (w_stale)
  );

  // Outputs decode straight from flops; the payload is forced to zero
  // outside the emit states so it reads as zero out of reset.
  assign rd_addr1  = r_rd_addr1;
  assign rd_addr2  = r_rd_addr2;
  assign out_valid = w_emit_lo || w_emit_hi;
  assign out_index = w_emit_lo ? {r_pair, 1'b0} :
                     w_emit_hi ? {r_pair, 1'b1} : '0;
  assign out_data  = w_emit_lo ? r_lo :
                     w_emit_hi ? r_hi : '0;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign stale     = w_stale;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, out_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr1, rd_addr2, out_index;
  logic [31:0] rd_data1, rd_data2, out_data;
  logic        out_valid, busy, done, stale;

  logic        start_s, abort_s, out_ready_s;
  logic [4:0]  rd_addr1_s, rd_addr2_s, out_index_s;
  logic [31:0] rd_data1_s, rd_data2_s, out_data_s;
  logic        out_valid_s, busy_s, done_s, stale_s;

  logic [31:0] rf    [32];
  logic [31:0] exp_d [32];

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Register file model: combinational reads, write at posedge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rd_data1   = rf[rd_addr1];
  assign rd_data2   = rf[rd_addr2];
  assign rd_data1_s = rf[rd_addr1_s];
  assign rd_data2_s = rf[rd_addr2_s];

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done), .stale(stale)
  );

  regfile_dump #(.SKIP_ZERO(1)) dut_skip (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
    .rd_addr1(rd_addr1_s), .rd_addr2(rd_addr2_s),
    .rd_data1(rd_data1_s), .rd_data2(rd_data2_s),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_index(out_index_s), .out_data(out_data_s),
    .busy(busy_s), .done(done_s), .stale(stale_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 32; i++) exp_d[i] = rf[i];
  endtask

  // Runs one dump from a negedge. Cycle n is the period after posedge n-1,
  // where posedge 0 samples start. Inputs for cycle n are driven at its
  // negedge and take effect at posedge n.
  task automatic run_dump(input int wr_cyc, input logic [4:0] wa, input logic [31:0] wd,
                          input int abort_cyc, input int restart_cyc, input int rdy_mode,
                          output int nbeats, output int done_cyc, output int first_cyc);
    int cyc, e;
    bit fin;
    logic pv, pr;
    logic [4:0] pi;
    logic [31:0] pd;
    logic [3:0] pat;
    pat = 4'b1001;
    nbeats = 0; done_cyc = -1; first_cyc = -1; e = 0; fin = 0;
    pv = 0; pr = 0; pi = 0; pd = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!fin) begin
      start     = (cyc == restart_cyc);
      abort     = (cyc == abort_cyc);
      rf_we     = (cyc == wr_cyc);
      rf_waddr  = wa;
      rf_wdata  = wd;
      out_ready = (rdy_mode == 0) ? 1'b1 : pat[cyc % 4];
      if (cyc == 1) begin
        chk("read_addr1", rd_addr1, 5'd0);
        chk("read_addr2", rd_addr2, 5'd1);
        chk("stale_cleared_on_start", stale, 1'b0);
        chk("busy_in_read", busy, 1'b1);
      end
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_index", out_index, pi);
        chk("hold_data", out_data, pd);
      end
      if (out_valid && out_ready && !abort) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("beat_index", out_index, e[4:0]);
        chk("beat_data", out_data, exp_d[e]);
        e++;
        nbeats++;
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1;
      end
      if (abort) fin = 1;
      pv = out_valid; pr = out_ready; pi = out_index; pd = out_data;
      if (!fin) begin
        @(negedge clk);
        cyc++;
        if (cyc > 400) begin
          chk("dump_done_seen", done, 1'b1);
          fin = 1;
        end
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rf_we = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    int nb, dc, fc, cyc, e;

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    start_s = 1'b0; abort_s = 1'b0; out_ready_s = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stale", stale, 1'b0);
    chk("rst_rd_addr1", rd_addr1, 5'd0);
    chk("rst_rd_addr2", rd_addr2, 5'd0);
    chk("rst_out_index", out_index, 5'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    write_reg(5'd8, 32'd1);
    write_reg(5'd9, 32'd2);
    write_reg(5'd29, 32'd252);

    // Basic dump, out_ready always high.
    for (int i = 0; i < 32; i++) exp_d[i] = 32'd0;
    exp_d[8] = 32'd1; exp_d[9] = 32'd2; exp_d[29] = 32'd252;
    run_dump(0, 5'd0, 32'd0, 0, 0, 0, nb, dc, fc);
    chk("a_beats", nb, 32);
    chk("a_first_cycle", fc, 2);
    chk("a_done_cycle", dc, 49);
    chk("a_stale", stale, 1'b0);
    chk("a_busy_after", busy, 1'b0);
    chk("a_done_after", done, 1'b0);

    // Backpressure on out_ready.
    run_dump(0, 5'd0, 32'd0, 0, 0, 1, nb, dc, fc);
    chk("b_beats", nb, 32);
    chk("b_done_seen", (dc > 49), 1'b1);
    chk("b_stale", stale, 1'b0);

    // Write r8 before pair 4 is captured: new value appears, not stale.
    snapshot();
    exp_d[8] = 32'hDEAD;
    run_dump(10, 5'd8, 32'hDEAD, 0, 0, 0, nb, dc, fc);
    chk("early_beats", nb, 32);
    chk("early_stale", stale, 1'b0);

    // Write r8 after pair 4 is captured: old value emitted, stale sticky.
    snapshot();
    run_dump(14, 5'd8, 32'hBEEF, 0, 0, 0, nb, dc, fc);
    chk("late_beats", nb, 32);
    chk("late_stale", stale, 1'b1);
    @(negedge clk);
    chk("late_stale_sticky", stale, 1'b1);

    // Abort during EMIT_HI of pair 3 (cycle 12); r1 overwritten earlier.
    snapshot();
    run_dump(5, 5'd1, 32'h55, 12, 0, 0, nb, dc, fc);
    chk("abort_beats", nb, 7);
    chk("abort_no_done_in_run", dc, -1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_stale_kept", stale, 1'b1);
    @(negedge clk);
    chk("abort_done_later", done, 1'b0);

    // Clean dump after abort; extra start mid-dump is ignored.
    snapshot();
    run_dump(0, 5'd0, 32'd0, 0, 10, 0, nb, dc, fc);
    chk("clean_beats", nb, 32);
    chk("clean_done_cycle", dc, 49);
    chk("clean_stale", stale, 1'b0);
    chk("clean_r1", exp_d[1], 32'h55);

    // SKIP_ZERO instance: 31 beats starting at index 1.
    snapshot();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc = 1; e = 1; nb = 0; dc = -1; fc = -1;
    while (dc < 0 && cyc < 200) begin
      if (out_valid_s) begin
        if (fc < 0) fc = cyc;
        chk("skip_index", out_index_s, e[4:0]);
        chk("skip_data", out_data_s, exp_d[e]);
        e++;
        nb++;
      end
      if (done_s) dc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("skip_beats", nb, 31);
    chk("skip_first_cycle", fc, 2);
    chk("skip_done_cycle", dc, 48);

    // Asynchronous reset mid-dump.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_busy", busy, 1'b0);
    chk("areset_rd_addr1", rd_addr1, 5'd0);
    chk("areset_rd_addr2", rd_addr2, 5'd0);
    chk("areset_out_index", out_index, 5'd0);
    chk("areset_out_data", out_data, 32'd0);
    chk("areset_stale", stale, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
Debug/trace reader for the 32x32 pipeline register file. On a start pulse it walks every register through the file's two combinational read ports, one even/odd pair at a time. Each value goes out as a valid/ready stream of (index, data) beats. It also snoops the file's write port and flags the snapshot as stale if the pipeline overwrites a register already captured. It sits beside the register file, sharing its read ports through the debug mux when the core is halted.

Parameters:
NUM_REGS, 32, registers dumped; must be even, ≤ 2**ADDR_W
ADDR_W, 5, register address width
DATA_W, 32, register data width
SKIP_ZERO, 0, 1 = omit the register-0 beat (hard zero)

Ports:
clk  in  1  posedge clock
reset  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request; ignored while busy
abort  in  1  cancel dump in progress
rd_addr1  out  ADDR_W  to register file ReadReg1 (even index)
rd_addr2  out  ADDR_W  to register file ReadReg2 (odd index)
rd_data1  in  DATA_W  from register file ReadData1
rd_data2  in  DATA_W  from register file ReadData2
rf_we  in  1  snooped RegWrite
rf_waddr  in  ADDR_W  snooped WriteReg
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat
out_index  out  ADDR_W  register number of beat
out_data  out  DATA_W  register value
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse after last beat accepted
stale  out  1  sticky: captured register overwritten during dump

Behaviour:
- Reset (async): state IDLE; rd_addr1/2=0; out_valid=0; out_index=0; out_data=0; busy=0; done=0; stale=0; pair counter=0; captured mask=0.
- States: IDLE, READ, EMIT_LO, EMIT_HI, DONE.
- IDLE: start → READ, pair=0, stale cleared, mask cleared; rd_addr1={pair,0}, rd_addr2={pair,1}, all registered outputs.
- READ: one cycle; addresses stable the whole cycle. At the closing edge, capture rd_data1/rd_data2 into lo/hi holding registers and set mask bits for both indices. Next state is EMIT_LO, or EMIT_HI when SKIP_ZERO=1 and pair==0.
- EMIT_LO: out_valid=1, out_index={pair,0}, out_data=lo. Holds until out_ready, then → EMIT_HI.
- EMIT_HI: same with hi and {pair,1}. On accept: if last pair → DONE; else pair+1, update addresses, → READ.
- DONE: done=1 for one cycle, → IDLE. busy=0 from the next cycle.
- out_index/out_data stay constant while out_valid && !out_ready. out_valid never drops without a handshake, except on abort/reset.
- Latency with out_ready held high, start sampled at edge 0:
  - READ cycle 1; first beat (index 0) in cycle 2.
  - Pair p: READ cycle 3p+1, LO 3p+2, HI 3p+3.
  - Index 31 beat in cycle 48; done in cycle 49.
- abort in any non-IDLE state: → IDLE at next edge, out_valid=0, no done pulse, stale retained. abort has priority over handshake. Abort in IDLE is ignored.
- start while busy: ignored. start and abort together in IDLE: start wins.
- Stale snoop: rf_we=1 at a posedge with mask[rf_waddr]=1 sets stale. A write to a pair in the same edge as its capture counts as stale (conservative). Writes outside a dump are ignored.
- Pair counter is ADDR_W-1 bits; last pair = NUM_REGS/2-1, so no wrap.

Decomposition:
- Shared package: state enum, NUM_REGS, ADDR_W, DATA_W defaults.
- One natural sub-module: regfile_dump_snoop, holding the captured mask and sticky stale bit (inputs: clear, capture pair, rf_we, rf_waddr).
- The FSM and holding registers stay in the top.

Test Plan:
- Preload r8=1, r9=2, r29=252, others 0; start, out_ready=1 → 32 beats, index 0..31 in order, data matches; first beat cycle 2, done cycle 49, stale=0.
- out_ready toggled 1-0-0-1 pseudo-randomly → same 32 beats, no duplicates or drops, out_data stable while stalled.
- SKIP_ZERO=1 → 31 beats starting index 1; done after index 31.
- During dump, write r8=0xDEAD after pair 4 captured → stale=1 and sticky until the next start. Same write before pair 4 captured → beat index 8 = 0xDEAD, stale=0.
- abort during EMIT_HI of pair 3 → next cycle IDLE, out_valid=0, busy=0, no done. A new start gives a full clean dump.
- reset asserted mid-dump (async, between edges) → all outputs at reset values immediately; start pulse during busy is ignored (beat count unchanged).
